// File: rtl/rgb_to_gray_stream_pkg.sv
// Shared definitions for the RGB-to-gray feeder and the edge-detection stage:
// FSM state encoding, luma coefficients, rounding constant and default frame
// geometry.
package rgb_to_gray_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stateT;

  localparam int DEF_WIDTH          = 768;
  localparam int DEF_HEIGHT         = 512;
  localparam int DEF_BITS_FOR_INDEX = 10;
  localparam int DEF_SIZE_OF_WIDTH  = 8;
  localparam int DEF_BIN_THRESHOLD  = 100;

  // BT.601 luma weights scaled by 256; they sum to 256, so full-scale input
  // maps to full-scale gray.
  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  // Half an LSB of the 8-bit result, added before truncation.
  localparam logic [16:0] LUMA_ROUND = 17'd128;

endpackage

// File: rtl/rgb_to_gray_stream_if.sv
// Pixel stream bundle between the RGB source, the gray converter and the
// edge-detection stage. The slave side is the converter.
interface rgb_to_gray_stream_if
  import rgb_to_gray_stream_pkg::*;
#(
  parameter int sizeOfWidth    = DEF_SIZE_OF_WIDTH,
  parameter int BITS_FOR_INDEX = DEF_BITS_FOR_INDEX
);

  logic                      in_valid;
  logic                      in_ready;
  logic [sizeOfWidth-1:0]    in_r;
  logic [sizeOfWidth-1:0]    in_g;
  logic [sizeOfWidth-1:0]    in_b;

  logic                      out_valid;
  logic [sizeOfWidth-1:0]    DATA_WRITE_R0;
  logic [BITS_FOR_INDEX-1:0] rowIndex;
  logic [BITS_FOR_INDEX-1:0] colIndex;
  logic                      frame_last;

  modport slave (
    input  in_valid, in_r, in_g, in_b,
    output in_ready, out_valid, DATA_WRITE_R0, rowIndex, colIndex, frame_last
  );

  modport master (
    output in_valid, in_r, in_g, in_b,
    input  in_ready, out_valid, DATA_WRITE_R0, rowIndex, colIndex, frame_last
  );

endinterface

// File: rtl/rgb_to_gray_stream_luma_pipe.sv
// Two-stage RGB-to-luma pipeline with valid/index/last sideband.
// Stage 1 registers the three weighted channels, stage 2 registers the
// rounded sum. Define GRAY_THRESHOLD_EN to binarise the stage-2 result
// against BIN_THRESHOLD (latency is the same either way).
module rgb_luma_pipe
  import rgb_to_gray_stream_pkg::*;
#(
  parameter int sizeOfWidth    = DEF_SIZE_OF_WIDTH,
  parameter int BITS_FOR_INDEX = DEF_BITS_FOR_INDEX,
  parameter int BIN_THRESHOLD  = DEF_BIN_THRESHOLD
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      inValid,
  input  logic [sizeOfWidth-1:0]    inR,
  input  logic [sizeOfWidth-1:0]    inG,
  input  logic [sizeOfWidth-1:0]    inB,
  input  logic [BITS_FOR_INDEX-1:0] inRow,
  input  logic [BITS_FOR_INDEX-1:0] inCol,
  input  logic                      inLast,
  output logic                      outValid,
  output logic [sizeOfWidth-1:0]    outGray,
  output logic [BITS_FOR_INDEX-1:0] outRow,
  output logic [BITS_FOR_INDEX-1:0] outCol,
  output logic                      outLast
);

  logic                      s1Valid;
  logic                      s1Last;
  logic [15:0]               s1R;
  logic [15:0]               s1G;
  logic [15:0]               s1B;
  logic [BITS_FOR_INDEX-1:0] s1Row;
  logic [BITS_FOR_INDEX-1:0] s1Col;

  logic [16:0]               sum;
  logic [sizeOfWidth-1:0]    gray;
  logic [sizeOfWidth-1:0]    pixOut;

  // Stage 1: weight each channel; data holds when no pixel enters.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s1Valid <= 1'b0;
      s1Last  <= 1'b0;
      s1R     <= '0;
      s1G     <= '0;
      s1B     <= '0;
      s1Row   <= '0;
      s1Col   <= '0;
    end else begin
      s1Valid <= inValid;
      s1Last  <= inValid & inLast;
      if (inValid) begin
        s1R   <= LUMA_R * 16'(inR);
        s1G   <= LUMA_G * 16'(inG);
        s1B   <= LUMA_B * 16'(inB);
        s1Row <= inRow;
        s1Col <= inCol;
      end
    end
  end

  // Worst case is 65408, so bit 16 never sets and no saturation is needed.
  assign sum  = {1'b0, s1R} + {1'b0, s1G} + {1'b0, s1B} + LUMA_ROUND;
  assign gray = sizeOfWidth'(sum[15:8]);

`ifdef GRAY_THRESHOLD_EN
  localparam logic [sizeOfWidth-1:0] THRESH = sizeOfWidth'(BIN_THRESHOLD);
  assign pixOut = (gray >= THRESH) ? '1 : '0;
`else
  logic unusedThreshold;
  assign unusedThreshold = ^sizeOfWidth'(BIN_THRESHOLD);
  assign pixOut = gray;
`endif

  logic unusedSumBits;
  assign unusedSumBits = ^{sum[16], sum[7:0]};

  // Stage 2: output register; valid/last pulse only with a fresh pixel.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      outValid <= 1'b0;
      outLast  <= 1'b0;
      outGray  <= '0;
      outRow   <= '0;
      outCol   <= '0;
    end else begin
      outValid <= s1Valid;
      outLast  <= s1Valid & s1Last;
      if (s1Valid) begin
        outGray <= pixOut;
        outRow  <= s1Row;
        outCol  <= s1Col;
      end
    end
  end

endmodule

// File: rtl/rgb_to_gray_stream.sv
// RGB-to-gray stream feeder for the edge-detection stage. Owns the frame
// FSM and raster counters; the luma math lives in rgb_luma_pipe.
// Optional build macro: GRAY_THRESHOLD_EN (binarised output).
//
//   state | meaning
//   IDLE  | waiting for start, in_ready low
//   RUN   | accepting pixels, raster counters advance on accept
//   DRAIN | last pixel accepted, waiting 2 cycles for it to leave stage 2
module rgb_to_gray_stream
  import rgb_to_gray_stream_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HEIGHT         = DEF_HEIGHT,
  parameter int BITS_FOR_INDEX = DEF_BITS_FOR_INDEX,
  parameter int sizeOfWidth    = DEF_SIZE_OF_WIDTH,
  parameter int BIN_THRESHOLD  = DEF_BIN_THRESHOLD
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  output logic                busy,
  rgb_to_gray_stream_if.slave px
);

  localparam logic [BITS_FOR_INDEX-1:0] COL_LAST = BITS_FOR_INDEX'(WIDTH - 1);
  localparam logic [BITS_FOR_INDEX-1:0] ROW_LAST = BITS_FOR_INDEX'(HEIGHT - 1);

  stateT                     stateQ;
  stateT                     stateD;
  logic                      drainCntQ;
  logic                      drainCntD;
  logic [BITS_FOR_INDEX-1:0] rowCnt;
  logic [BITS_FOR_INDEX-1:0] colCnt;
  logic                      accept;
  logic                      atLast;

  assign px.in_ready = (stateQ == RUN);
  assign busy        = (stateQ != IDLE);
  assign accept      = px.in_valid & px.in_ready;
  assign atLast      = (rowCnt == ROW_LAST) && (colCnt == COL_LAST);

  // State register and drain down-counter.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      stateQ    <= IDLE;
      drainCntQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      drainCntQ <= drainCntD;
    end
  end

  // Next state; the drain counter is loaded with 1 so DRAIN lasts exactly two
  // cycles, matching the pipeline depth. start is only honoured in IDLE.
  always_comb begin
    stateD    = stateQ;
    drainCntD = drainCntQ;
    case (stateQ)
      IDLE: begin
        if (start) stateD = RUN;
      end
      RUN: begin
        if (accept && atLast) begin
          stateD    = DRAIN;
          drainCntD = 1'b1;
        end
      end
      DRAIN: begin
        if (drainCntQ == 1'b0) stateD = IDLE;
        else drainCntD = drainCntQ - 1'b1;
      end
      default: stateD = IDLE;
    endcase
  end

  // Raster position of the next pixel to accept; cleared when a frame is armed.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rowCnt <= '0;
      colCnt <= '0;
    end else if ((stateQ == IDLE) && start) begin
      rowCnt <= '0;
      colCnt <= '0;
    end else if (accept) begin
      if (colCnt == COL_LAST) begin
        colCnt <= '0;
        rowCnt <= atLast ? '0 : rowCnt + 1'b1;
      end else begin
        colCnt <= colCnt + 1'b1;
      end
    end
  end

  rgb_luma_pipe #(
    .sizeOfWidth   (sizeOfWidth),
    .BITS_FOR_INDEX(BITS_FOR_INDEX),
    .BIN_THRESHOLD (BIN_THRESHOLD)
  ) u_luma_pipe (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .inValid (accept),
    .inR     (px.in_r),
    .inG     (px.in_g),
    .inB     (px.in_b),
    .inRow   (rowCnt),
    .inCol   (colCnt),
    .inLast  (atLast),
    .outValid(px.out_valid),
    .outGray (px.DATA_WRITE_R0),
    .outRow  (px.rowIndex),
    .outCol  (px.colIndex),
    .outLast (px.frame_last)
  );

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed bench for rgb_to_gray_stream on a 4x3 frame with a scoreboard of
// expected output pixels (value, indices, last flag, due cycle).
module tb_rgb_to_gray_stream;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int BI  = 10;
  localparam int SW  = 8;
  localparam int THR = 100;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic start   = 1'b0;
  logic busy;

  rgb_to_gray_stream_if #(.sizeOfWidth(SW), .BITS_FOR_INDEX(BI)) px ();

  rgb_to_gray_stream #(
    .WIDTH(W), .HEIGHT(H), .BITS_FOR_INDEX(BI), .sizeOfWidth(SW), .BIN_THRESHOLD(THR)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .busy(busy), .px(px)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0] gray;
    logic [9:0] row;
    logic [9:0] col;
    logic       last;
    int         due;
  } expT;

  expT  sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic expReady = 1'b0;
  int   mRow     = 0;
  int   mCol     = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] refGray(input int r, input int g, input int b);
    int s;
    s = (77 * r + 150 * g + 29 * b + 128) / 256;
`ifdef GRAY_THRESHOLD_EN
    return (s >= THR) ? 8'hFF : 8'h00;
`else
    return 8'(s);
`endif
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic drivePix(input logic v, input int r, input int g, input int b, input logic st);
    expT e;
    px.in_valid = v;
    px.in_r     = 8'(r);
    px.in_g     = 8'(g);
    px.in_b     = 8'(b);
    start       = st;
    chk("in_ready", px.in_ready, expReady);
    @(posedge HCLK);
    if (v && expReady) begin
      e.gray = refGray(r, g, b);
      e.row  = 10'(mRow);
      e.col  = 10'(mCol);
      e.last = (mRow == H - 1) && (mCol == W - 1);
      e.due  = cyc + 2;
      sbq.push_back(e);
      if (e.last) expReady = 1'b0;
      if (mCol == W - 1) begin
        mCol = 0;
        mRow = (mRow == H - 1) ? 0 : mRow + 1;
      end else begin
        mCol++;
      end
    end
    @(negedge HCLK);
    px.in_valid = 1'b0;
    start       = 1'b0;
  endtask

  task automatic randPix(input logic v, input logic st);
    drivePix(v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), st);
  endtask

  task automatic doStart();
    start       = 1'b1;
    px.in_valid = 1'b0;
    @(posedge HCLK);
    expReady = 1'b1;
    mRow     = 0;
    mCol     = 0;
    @(negedge HCLK);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_in_ready"},   px.in_ready, 0);
    chk({tag, "_out_valid"},  px.out_valid, 0);
    chk({tag, "_data"},       px.DATA_WRITE_R0, 0);
    chk({tag, "_row"},        px.rowIndex, 0);
    chk({tag, "_col"},        px.colIndex, 0);
    chk({tag, "_frame_last"}, px.frame_last, 0);
    chk({tag, "_busy"},       busy, 0);
  endtask

  // Output monitor: every valid output must match the head of the scoreboard
  // and appear exactly on its due cycle.
  always @(negedge HCLK) begin
    expT e;
    if (HRESETn === 1'b1) begin
      if (px.out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", px.out_valid, 0);
        end else begin
          e = sbq.pop_front();
          chk("gray",       px.DATA_WRITE_R0, e.gray);
          chk("rowIndex",   px.rowIndex, e.row);
          chk("colIndex",   px.colIndex, e.col);
          chk("frame_last", px.frame_last, e.last);
          chk("latency",    cyc, e.due);
        end
      end else begin
        chk("frame_last_no_valid", px.frame_last, 0);
      end
    end
  end

  initial begin
    px.in_valid = 1'b0;
    px.in_r     = '0;
    px.in_g     = '0;
    px.in_b     = '0;

    // Reset
    repeat (3) @(negedge HCLK);
    checkZero("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);
    checkZero("idle");

    // Pixels before any start are refused
    repeat (3) drivePix(1'b1, 10, 20, 30, 1'b0);
    repeat (3) @(negedge HCLK);

    // Frame A: known values, then reset after 10 accepted pixels
    doStart();
    drivePix(1'b1, 255, 255, 255, 1'b0);
    drivePix(1'b1, 0, 0, 0, 1'b0);
    drivePix(1'b1, 255, 0, 0, 1'b0);
    drivePix(1'b1, 99, 99, 99, 1'b0);
    drivePix(1'b1, 100, 100, 100, 1'b0);
    drivePix(1'b1, 0, 255, 0, 1'b0);
    drivePix(1'b1, 0, 0, 255, 1'b0);
    repeat (3) randPix(1'b1, 1'b0);
    @(posedge HCLK);
    #1 HRESETn = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    checkZero("midreset");
    sbq.delete();
    expReady = 1'b0;
    HRESETn  = 1'b1;
    @(negedge HCLK);
    chk("post_reset_busy", busy, 0);

    // Frame B: bubbles 1,0,0,1 and a start pulse during RUN
    doStart();
    randPix(1'b1, 1'b0);
    randPix(1'b0, 1'b0);
    randPix(1'b0, 1'b0);
    randPix(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) randPix(1'b1, i == 3);
    chk("drain_busy", busy, 1);
    chk("drain_in_ready", px.in_ready, 0);
    @(negedge HCLK);
    chk("B_frame_last", px.frame_last, 1);
    chk("B_busy_at_last", busy, 1);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    chk("start_at_drain_exit_busy", busy, 0);
    chk("start_at_drain_exit_ready", px.in_ready, 0);
    @(negedge HCLK);
    chk("still_idle", busy, 0);

    // Frame C: continuous full frame
    doStart();
    for (int i = 0; i < W * H; i++) randPix(1'b1, 1'b0);
    chk("C_busy_drain", busy, 1);
    @(negedge HCLK);
    chk("C_frame_last", px.frame_last, 1);
    chk("C_busy_at_last", busy, 1);
    @(negedge HCLK);
    chk("C_busy_dropped", busy, 0);
    drivePix(1'b1, 1, 2, 3, 1'b0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge HCLK);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_to_gray_stream.md
Name: rgb_to_gray_stream

Overview:
- Upstream feeder for the edge-detection stage.
- Accepts a raster-ordered stream of 24-bit RGB pixels and converts each to 8-bit luma, using a 2-stage pipeline.
- Emits gray byte plus rowIndex/colIndex in exactly the form the edge stage samples: one pixel per valid cycle, row-major, (0,0) first.
- Tracks frame position itself and flags the last pixel of each frame.

Parameters:
- WIDTH, 768, image width in pixels
- HEIGHT, 512, image height in pixels
- BITS_FOR_INDEX, 10, width of row/col indices; must satisfy 2^BITS_FOR_INDEX >= max(WIDTH, HEIGHT)
- sizeOfWidth, 8, bits per colour channel and per gray output
- BIN_THRESHOLD, 100, binarisation threshold (used only with optional feature)

Ports:
- HCLK  in  1  clock, all logic on rising edge
- HRESETn  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; arms a new frame when idle
- in_valid  in  1  RGB pixel present on in_r/in_g/in_b
- in_ready  out  1  block accepts pixel this cycle
- in_r  in  sizeOfWidth  red channel
- in_g  in  sizeOfWidth  green channel
- in_b  in  sizeOfWidth  blue channel
- out_valid  out  1  DATA_WRITE_R0/rowIndex/colIndex valid this cycle
- DATA_WRITE_R0  out  sizeOfWidth  gray pixel
- rowIndex  out  BITS_FOR_INDEX  row of output pixel
- colIndex  out  BITS_FOR_INDEX  column of output pixel
- frame_last  out  1  high with out_valid on pixel (HEIGHT-1, WIDTH-1)
- busy  out  1  high from accepted start until pipeline drained

Behaviour:
- Reset (HRESETn=0 at posedge): state=IDLE, counters=0, both pipeline valid bits=0.
  - All outputs 0: in_ready, out_valid, DATA_WRITE_R0, rowIndex, colIndex, frame_last, busy.
  - Reset mid-frame discards in-flight pixels; no frame_last is produced.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DRAIN when the pixel at (HEIGHT-1, WIDTH-1) is accepted.
  - DRAIN -> IDLE when the last pixel has left stage 2 (exactly 2 cycles after acceptance).
  - start outside IDLE is ignored.
- in_ready = (state==RUN). Combinational from state only; never depends on in_valid.
- Accept occurs when in_valid && in_ready.
  - On accept, col counter increments.
  - At col=WIDTH-1, col wraps to 0 and row increments.
  - Counters reset to 0 on entry to RUN.
- Stage 1 (registered): pR=77*R, pG=150*G, pB=29*B, each 16 bit. Row/col and a valid bit travel alongside.
- Stage 2 (registered): sum=pR+pG+pB+128 in 17 bits; gray=sum[15:8].
  - Maximum sum is 65408, so no overflow and no saturation needed.
- Latency: out_valid rises exactly 2 cycles after the accept cycle. Output registers hold their value when no new pixel arrives; out_valid=0 in that case.
- No output backpressure: the downstream stage samples every cycle out_valid=1.
- Gaps in in_valid produce matching gaps in out_valid. Index order is unaffected.
- frame_last is asserted only together with out_valid.
- busy = (state!=IDLE).
- A start in the same cycle as the DRAIN->IDLE transition is ignored. It must be re-issued once busy=0.

Optional Feature:
- Macro GRAY_THRESHOLD_EN.
- Defined: stage 2 binarises. DATA_WRITE_R0 = 8'hFF if gray >= BIN_THRESHOLD, else 8'h00. Latency unchanged.
- Undefined: DATA_WRITE_R0 = gray. BIN_THRESHOLD is unused.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DRAIN)
  - luma coefficients 77/150/29
  - rounding constant 128
  - default WIDTH/HEIGHT/BITS_FOR_INDEX, reused by the edge stage
- One natural sub-module: rgb_luma_pipe. It holds the 2-stage multiply/sum pipeline with a valid/index sideband. The top level keeps the FSM and raster counters.

Test Plan:
- Reset mid-frame: reset after 10 accepted pixels, then start a new frame. First output has row=0, col=0; no frame_last before frame end.
- Single pixel R=G=B=255 accepted at cycle t: DATA_WRITE_R0=255 and out_valid=1 at t+2. R=G=B=0 gives 0. R=255,G=0,B=0 gives 77.
- WIDTH=4, HEIGHT=3 full frame with continuous in_valid:
  - 12 outputs in order (0,0)..(2,3); col wraps 3->0 with row increment.
  - frame_last on the 12th output only; busy drops 1 cycle after frame_last.
- Bubbles: in_valid toggled 1,0,0,1. out_valid shows the same pattern shifted by 2 cycles; indices consecutive.
- start pulsed while in RUN has no effect on the counters. start before the first start: in_ready=0, inputs ignored.
- GRAY_THRESHOLD_EN defined, BIN_THRESHOLD=100: gray 99 -> 0x00; gray 100 -> 0xFF. R=G=B=100 -> 0xFF.
